// File: rtl/arb_mux2_if.sv
// Flit bus for the two-input packet arbiter/mux: two input ports, one registered
// output port, plus grant-holder id and lock status observed by the environment.
interface arb_mux2_if #(
    parameter int DATA_W = 32
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_last;
    logic              in0_ready;

    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_last;
    logic              in1_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    logic              cur_arb_id;
    logic              busy;

    // Environment side: sources the input flits and the downstream ready.
    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  cur_arb_id, busy
    );

    // Arbiter side.
    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output cur_arb_id, busy
    );
endinterface

// File: rtl/arb_mux2.sv
// Two-input packet arbiter: grants one port per packet (last winner lowest priority),
// forwards its flits through a single registered output stage until the tail flit.
module arb_mux2 #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_mux2_if.slave   bus
);

    // Handshakes: a flit moves on a rising edge when valid and ready are both high
    // in the preceding cycle; ready never depends on the same port's valid.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_q;
    logic              grant_nxt;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;

    logic [1:0]        req;
    logic              other;
    logic              winner;
    logic              take;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              accept;

    // Output stage can take a flit when empty or being drained this cycle.
    assign take = !out_valid_q || bus.out_ready;

    always_comb begin
        req       = {bus.in1_valid, bus.in0_valid};
        other     = ~grant_q;
        winner    = req[other] ? other : grant_q;
        sel_valid = grant_q ? bus.in1_valid : bus.in0_valid;
        sel_data  = grant_q ? bus.in1_data  : bus.in0_data;
        sel_last  = grant_q ? bus.in1_last  : bus.in0_last;
        accept    = (state == BUSY) && sel_valid && take;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
        end
    end

    // Output register drains on its own, regardless of the packet lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in0_ready  = (state == BUSY) && !grant_q && take;
    assign bus.in1_ready  = (state == BUSY) &&  grant_q && take;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.cur_arb_id = grant_q;
    assign bus.busy       = (state == BUSY);

endmodule

// File: tb/tb_arb_mux2.sv
// Bench for arb_mux2: packet-level round-robin model feeds an expected queue,
// an output monitor pops and compares every output handshake.
module tb_arb_mux2;
  localparam int DATA_W = 32;
  localparam int FW = DATA_W + 2;  // {first, last, data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  arb_mux2_if #(.DATA_W(DATA_W)) bus();

  arb_mux2 #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic              in_valid[2];
  logic [DATA_W-1:0] in_data[2];
  logic              in_last[2];
  logic              rdy[2];
  logic              out_rdy = 1'b1;

  assign bus.in0_valid = in_valid[0];
  assign bus.in0_data  = in_data[0];
  assign bus.in0_last  = in_last[0];
  assign bus.in1_valid = in_valid[1];
  assign bus.in1_data  = in_data[1];
  assign bus.in1_last  = in_last[1];
  assign bus.out_ready = out_rdy;
  assign rdy[0] = bus.in0_ready;
  assign rdy[1] = bus.in1_ready;

  logic [FW-1:0]     pq[2][$];
  logic [FW-1:0]     stage[2][$];
  logic [DATA_W:0]   exp_q[$];
  int                hs_cyc[$];
  int                total = 0;
  int                bad = 0;
  int                cyc = 0;
  int                gap_pct = 0;
  logic              model_last = 1'b0;
  bit                tail_busy_chk = 1'b0;
  bit                rand_rdy = 1'b0;
  bit                fixed_rdy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- clock/reset helpers and checks ----------------
  task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic wait_busy(input string name, input logic val, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== val && n < budget);
    if (bus.busy !== val) begin
      total++;
      bad++;
      $display("FAIL %s busy=%b expected=%b (timeout)", name, bus.busy, val);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    bit left;
    left = 1'b1;
    while (left && n < budget) begin
      @(posedge clk);
      #2;
      n++;
      left = (exp_q.size() != 0) || (pq[0].size() != 0) || (pq[1].size() != 0) || bus.out_valid;
    end
    total++;
    if (left) begin
      bad++;
      $display("FAIL drain_%s left=%0d expected=0", name, exp_q.size());
      exp_q.delete();
      pq[0].delete();
      pq[1].delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_gaps(input string name, input int gap);
    bit ok;
    ok = (hs_cyc.size() >= 2);
    for (int i = 1; i < hs_cyc.size(); i++)
      if (hs_cyc[i] - hs_cyc[i-1] != gap) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s handshakes=%0d spacing not all %0d", name, hs_cyc.size(), gap);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void stage_pkt(input int p, input logic [DATA_W-1:0] base, input int len, input bit rnd);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
      if (rnd) d[DATA_W-1] = p[0];
      stage[p].push_back({(i == 0), (i == len - 1), d});
    end
  endfunction

  // Packet-level round robin: when both ports have packets waiting, the port that
  // did not win last time goes next; a lone port always goes.
  function automatic void merge_expect();
    logic          p;
    logic [FW-1:0] f;
    while (stage[0].size() > 0 || stage[1].size() > 0) begin
      p = (stage[!model_last].size() > 0) ? !model_last : model_last;
      do begin
        f = stage[p].pop_front();
        exp_q.push_back(f[DATA_W:0]);
        pq[p].push_back(f);
      end while (!f[DATA_W] && stage[p].size() > 0);
      model_last = p;
    end
  endfunction

  // ---------------- drivers ----------------
  initial begin
    bit acc[2];
    logic [FW-1:0] f;
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0;
      in_data[p]  = '0;
      in_last[p]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) acc[p] = rst_n && in_valid[p] && rdy[p];
      @(posedge clk);
      #1;
      out_rdy = rand_rdy ? ($urandom_range(99) < 70) : fixed_rdy;
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          in_valid[p] = 1'b0;
        end else begin
          if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
          if (pq[p].size() == 0) begin
            in_valid[p] = 1'b0;
          end else if (!(in_valid[p] && !acc[p])) begin
            f = pq[p][0];
            in_data[p]  = f[DATA_W-1:0];
            in_last[p]  = f[DATA_W];
            in_valid[p] = f[DATA_W+1] ? 1'b1 : ($urandom_range(99) >= gap_pct);
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [DATA_W:0] got;
    logic [DATA_W:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        got = {bus.out_last, bus.out_data};
        hs_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_flit got=%h expected=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL out_flit got=%h expected=%h", got, e);
          end
        end
        if (tail_busy_chk && bus.out_last) begin
          total++;
          if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL tail_busy got=%b expected=0", bus.busy);
          end
        end
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int viol;
    int n0, n1;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cur_id", bus.cur_arb_id, 0);
    check("rst_in0_ready", rdy[0], 0);
    check("rst_in1_ready", rdy[1], 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Both ports request at once right after reset: port 1 first.
    tail_busy_chk = 1'b1;
    @(posedge clk);
    #2;
    hs_cyc.delete();
    stage_pkt(0, 32'hA0, 1, 1'b0);
    stage_pkt(1, 32'hB1, 1, 1'b0);
    merge_expect();
    wait_busy("arb_first_wait", 1'b1, 20);
    check("arb_first_id", bus.cur_arb_id, 1);
    wait_busy("arb_gap_wait", 1'b0, 20);
    wait_busy("arb_second_wait", 1'b1, 20);
    check("arb_second_id", bus.cur_arb_id, 0);
    wait_drain("pair", 50);
    check_gaps("pkt_gap_2", 2);

    // Four-flit burst from port 0 alone.
    hs_cyc.delete();
    stage_pkt(0, 32'h10, 4, 1'b0);
    merge_expect();
    wait_drain("burst", 50);
    check_gaps("burst_consec", 1);

    // Port 1 shows up mid-packet while port 0 holds the lock.
    stage_pkt(0, 32'h20, 3, 1'b0);
    merge_expect();
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        stage_pkt(1, 32'h30, 2, 1'b0);
        merge_expect();
      end
      if (bus.busy && !bus.cur_arb_id && rdy[1]) viol++;
    end
    check("lock_in1_ready_viol", viol, 0);
    wait_drain("lock", 50);

    // Downstream stall holds the output register.
    fixed_rdy = 1'b0;
    @(posedge clk);
    #2;
    stage_pkt(0, 32'h55, 2, 1'b0);
    merge_expect();
    viol = 0;
    while (!bus.out_valid && viol < 20) begin
      @(negedge clk);
      viol++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", bus.out_data, 32'h55);
      check("stall_in0_ready", rdy[0], 0);
    end
    fixed_rdy = 1'b1;
    wait_drain("stall", 50);

    // Reset during flit 2 of a port 1 packet.
    stage_pkt(1, 32'h70, 4, 1'b0);
    merge_expect();
    viol = 0;
    do begin
      @(negedge clk);
      viol++;
    end while (!(bus.out_valid && bus.out_data == 32'h70) && viol < 20);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_out_last", bus.out_last, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_cur_id", bus.cur_arb_id, 0);
    check("arst_in1_ready", rdy[1], 0);
    exp_q.delete();
    pq[0].delete();
    pq[1].delete();
    model_last = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    stage_pkt(0, 32'hC0, 1, 1'b0);
    stage_pkt(1, 32'hD1, 1, 1'b0);
    merge_expect();
    wait_busy("post_rst_wait", 1'b1, 20);
    check("post_rst_grant", bus.cur_arb_id, 1);
    wait_drain("post_rst", 50);

    // Eight single-flit packets on each port: strict alternation.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      stage_pkt(0, 32'h100 + i, 1, 1'b0);
      stage_pkt(1, 32'h200 + i, 1, 1'b0);
    end
    merge_expect();
    wait_drain("alt", 100);
    check_gaps("alt_gap", 2);

    // Randomized packets, mid-packet valid gaps and downstream stalls.
    tail_busy_chk = 1'b0;
    gap_pct = 30;
    rand_rdy = 1'b1;
    for (int r = 0; r < 12; r++) begin
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      for (int k = 0; k < n0; k++) stage_pkt(0, '0, $urandom_range(1, 5), 1'b1);
      for (int k = 0; k < n1; k++) stage_pkt(1, '0, $urandom_range(1, 5), 1'b1);
      merge_expect();
      wait_drain("random", 600);
    end
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog time=%0t expected=finished", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
